// File: rtl/seq_gen_prog.sv
// Programmable sequence generator: steps through a writable code table
// with a one-shot preamble (entries below loop) and a repeating body.
module seq_gen_prog #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cfg_wr,
  input  logic [AW:0]      cfg_len,
  input  logic [AW-1:0]    cfg_loop,
  output logic [WIDTH-1:0] cq,
  output logic [AW-1:0]    idx,
  output logic             wrap,
  output logic             cfg_err
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] seq_table [DEPTH];

  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] loop_q, loop_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic cfg_ok;
  logic at_last;
  logic wr_ok;

  // A configuration must describe a non-empty sequence that fits the table,
  // with its loop-back point inside the active region.
  assign cfg_ok  = cfg_wr && (cfg_len != '0) && (cfg_len <= DEPTH_L) &&
                   ({1'b0, cfg_loop} < cfg_len);
  assign at_last = ({1'b0, idx_q} == (len_q - 1'b1));
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_L);

  always_comb begin
    idx_d  = idx_q;
    len_d  = len_q;
    loop_d = loop_q;
    wrap_d = 1'b0;
    err_d  = cfg_wr && !cfg_ok;

    if (cfg_ok) begin
      len_d  = cfg_len;
      loop_d = cfg_loop;
      idx_d  = '0;
    end else if (restart) begin
      idx_d = '0;
    end else if (en) begin
      if (at_last) begin
        idx_d  = loop_q;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      len_q  <= DEPTH_L;
      loop_q <= AW'(1);
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      len_q  <= len_d;
      loop_q <= loop_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  // Reset loads an identity ramp (truncated to WIDTH) so the block is usable unprogrammed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        seq_table[i] <= WIDTH'(i);
      end
    end else if (wr_ok) begin
      seq_table[wr_addr] <= wr_data;
    end
  end

  assign cq      = seq_table[idx_q];
  assign idx     = idx_q;
  assign wrap    = wrap_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_seq_gen_prog.sv
// Scoreboard bench for seq_gen_prog: driver predicts with a behavioural model,
// monitor compares DUT outputs after every clock edge.
module tb_seq_gen_prog;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst, en, restart, wr_en, cfg_wr;
  logic [AW-1:0]    wr_addr, cfg_loop;
  logic [WIDTH-1:0] wr_data;
  logic [AW:0]      cfg_len;
  logic [WIDTH-1:0] cq;
  logic [AW-1:0]    idx;
  logic             wrap, cfg_err;

  seq_gen_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_wr(cfg_wr), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
    .cq(cq), .idx(idx), .wrap(wrap), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] cq;
    logic             wrap;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_table [DEPTH];
  int m_idx, m_len, m_loop;
  int m_wrap, m_err;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and predict the state after the coming edge.
  task automatic applyStimulus(input logic r, input logic e, input logic rs,
                               input logic we, input int wa, input int wd,
                               input logic cw, input int cl, input int clp);
    exp_t x;
    bit   ok;
    @(negedge clk);
    rst = r; en = e; restart = rs; wr_en = we;
    wr_addr = AW'(wa); wr_data = WIDTH'(wd);
    cfg_wr = cw; cfg_len = (AW+1)'(cl); cfg_loop = AW'(clp);
    if (r) begin
      m_idx = 0; m_len = DEPTH; m_loop = 1; m_wrap = 0; m_err = 0;
      for (int i = 0; i < DEPTH; i++) m_table[i] = i % (1 << WIDTH);
    end else begin
      ok = cw && cl >= 1 && cl <= DEPTH && clp < cl;
      if (we && wa < DEPTH) m_table[wa] = wd;
      m_wrap = 0;
      m_err  = (cw && !ok) ? 1 : 0;
      if (ok) begin
        m_len = cl; m_loop = clp; m_idx = 0;
      end else if (rs) begin
        m_idx = 0;
      end else if (e) begin
        if (m_idx == m_len - 1) begin
          m_idx = m_loop; m_wrap = 1;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end
    x.idx  = AW'(m_idx);
    x.cq   = WIDTH'(m_table[m_idx]);
    x.wrap = m_wrap[0];
    x.err  = m_err[0];
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("idx", 8'(idx), 8'(mon_e.idx));
      checkOutput("cq", 8'(cq), 8'(mon_e.cq));
      checkOutput("wrap", 8'(wrap), 8'(mon_e.wrap));
      checkOutput("cfg_err", 8'(cfg_err), 8'(mon_e.err));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int tbl[7];
    tbl = '{0, 2, 5, 3, 4, 6, 1};
    rst = 1; en = 0; restart = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    cfg_wr = 0; cfg_len = 0; cfg_loop = 0;

    $display("[TB] reset and free-run with default table");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(16);

    $display("[TB] program 7-entry table with loop at 1");
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, i, tbl[i], 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 7, 1);
    step(14);

    $display("[TB] rejected configurations");
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 9, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 4, 4);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0);
    step(3);

    $display("[TB] restart and configure-with-restart");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(5);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(3);
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 5, 2);
    step(8);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 0);
    step(4);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 8, 7);
    step(10);

    $display("[TB] write to current entry while held, then mid-run reset");
    applyStimulus(0, 0, 0, 1, m_idx, 15, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(3);
    applyStimulus(1, 1, 1, 1, 2, 9, 1, 3, 1);
    step(10);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 80,
                    $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, DEPTH - 1),
                    $urandom_range(0, (1 << WIDTH) - 1),
                    $urandom_range(0, 99) < 6,
                    $urandom_range(0, 15),
                    $urandom_range(0, DEPTH - 1));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #3;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen_prog.md
SEQ_GEN_PROG -- requirements
Module: seq_gen_prog

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, output code width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 8, number of sequence-table entries (>=2).
REQ-003 The module SHALL define local AW = clog2(DEPTH), the index width.
REQ-004 The module SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: en  input  1  advance sequence one step per cycle when high.
REQ-008 Port: restart  input  1  force index to 0 at next edge.
REQ-009 Port: wr_en  input  1  table write strobe.
REQ-010 Port: wr_addr  input  AW  table entry to write.
REQ-011 Port: wr_data  input  WIDTH  code to store.
REQ-012 Port: cfg_wr  input  1  length/loop configuration strobe.
REQ-013 Port: cfg_len  input  AW+1  active sequence length.
REQ-014 Port: cfg_loop  input  AW  loop-back index after last active entry.
REQ-015 Port: cq  output  WIDTH  current code, table[idx], combinational read of registered state.
REQ-016 Port: idx  output  AW  current table index (registered).
REQ-017 Port: wrap  output  1  registered one-cycle pulse marking a loop-back step.
REQ-018 Port: cfg_err  output  1  registered one-cycle pulse marking a rejected configuration.

Function
REQ-019 State SHALL be: table[DEPTH] of WIDTH bits, idx, len (AW+1 bits), loop (AW bits), wrap, cfg_err; all update only on rising clk.
REQ-020 Step rule: if idx == len-1 then idx <= loop and wrap <= 1, else idx <= idx+1 and wrap <= 0.
REQ-021 idx SHALL step only when en=1; with en=0 idx holds and wrap <= 0.
REQ-022 Entries 0..loop-1 SHALL act as a one-shot preamble; entries loop..len-1 SHALL repeat indefinitely.
REQ-023 cfg_wr is accepted only if 1 <= cfg_len <= DEPTH and cfg_loop < cfg_len; on accept len <= cfg_len, loop <= cfg_loop, idx <= 0, wrap <= 0, cfg_err <= 0.
REQ-024 On rejected cfg_wr, len, loop and idx SHALL be unchanged, en/restart SHALL be processed normally, and cfg_err <= 1 for one cycle.
REQ-025 len=1 (loop=0) SHALL hold idx at 0 with wrap=1 on every enabled cycle.
REQ-026 Priority for idx: rst > accepted cfg_wr > restart > en step > hold.
REQ-027 restart SHALL set idx <= 0 and wrap <= 0 regardless of en.
REQ-028 wr_en SHALL write table[wr_addr] <= wr_data at the edge; wr_addr >= DEPTH is ignored with no error.
REQ-029 Table writes are independent of and concurrent with cfg_wr, restart and en; a write to the currently indexed entry is visible on cq the cycle after the edge.
REQ-030 cq SHALL always equal table[idx]; there is no additional output latency.
REQ-031 wrap and cfg_err SHALL never be asserted longer than one cycle per event.

Reset
REQ-032 rst=1 at an edge SHALL set idx=0, len=DEPTH, loop=1, wrap=0, cfg_err=0, and table[i] = i mod 2^WIDTH for all i, overriding every other input that cycle.
REQ-033 Reset mid-sequence SHALL take effect at the next edge; after deassertion the sequence restarts from index 0 with reset table contents.

Verification (WIDTH=4, DEPTH=8)
REQ-034 Reset then en=1 for 16 cycles -> cq 0,1,2,3,4,5,6,7,1,2,...,7,1; wrap high exactly on cycles where idx goes 7->1.
REQ-035 Write table 0..6 = 0,2,5,3,4,6,1, cfg_wr len=7 loop=1, en=1 -> cq 0,2,5,3,4,6,1,2,5,3,4,6,1,2; wrap on each 1->2 transition.
REQ-036 cfg_wr len=9 loop=0, then len=4 loop=4, with en=1 -> cfg_err pulses each time, len/loop unchanged, idx continues stepping.
REQ-037 restart and en both high at idx=5 -> idx=0, cq=table[0], wrap=0; simultaneous cfg_wr (valid) and restart -> idx=0, new len/loop applied.
REQ-038 Write wr_addr=idx with wr_data=4'hF while en=0 -> cq=4'hF next cycle; rst asserted mid-run -> idx=0, cq=0, len=8, loop=1 next cycle.
